// File: rtl/pwm_sample_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_feeder_pkg
// Purpose  : Shared definitions for the PWM sample feeder and the audio path.
//            Holds the dither LFSR constants, the LFSR step function, a
//            saturating signed add, and the frame-boundary pop outcome type.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pwm_sample_feeder_pkg;

   // Dither LFSR: x^16 + x^14 + x^13 + x^11 + 1, maximal length.
   // Galois form, right shift: the feedback mask carries bits 15,13,12,10.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // What the frame boundary does with the buffer.
   typedef enum logic [1:0] {
      POP_NONE      = 2'd0,
      POP_DATA      = 2'd1,
      POP_UNDERFLOW = 2'd2
   } pop_kind_e;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] n;
      n = {1'b0, s[15:1]};
      if (s[0]) n = n ^ LFSR_TAPS;
      return n;
   endfunction

   // Signed add clamped to the range of a w-bit two's complement value.
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input int unsigned        w
   );
      logic signed [32:0] s;
      logic signed [32:0] hi;
      logic signed [32:0] lo;
      s  = 33'(a) + 33'(b);
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (s > hi) return 32'(hi);
      if (s < lo) return 32'(lo);
      return 32'(s);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_feeder_if
// Purpose  : valid/ready sample stream into the PWM sample feeder.
// Signals  : sample_in    - signed audio sample
//            sample_valid - sample_in is valid
//            sample_ready - feeder can accept a sample
// Modports : master (sample source), slave (feeder)
// Revision : 1.0  initial release
// ============================================================================
interface pwm_sample_feeder_if #(
   parameter int DATA_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] sample_in;
   logic                  sample_valid;
   logic                  sample_ready;

   modport master (output sample_in, output sample_valid, input sample_ready);
   modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface
`default_nettype wire

// File: rtl/pwm_sample_feeder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with separately tracked occupancy.
// Ports    : clk, rst_n (async active-low)
//            push/wdata  - write an entry (ignored when full)
//            pop         - remove the head entry (ignored when empty)
//            rdata       - current head entry
//            level       - occupancy, 0..DEPTH
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  wire logic                     clk,
   input  wire logic                     rst_n,
   input  wire logic                     push,
   input  wire logic [WIDTH-1:0]         wdata,
   input  wire logic                     pop,
   output logic      [WIDTH-1:0]         rdata,
   output logic      [$clog2(DEPTH):0]   level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (level != LVL_FULL);
   assign do_pop  = pop  && (level != '0);
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage is not reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/pwm_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_feeder
// Purpose  : Rate-matching stage in front of the PWM audio output. Buffers
//            incoming samples and releases one per PWM frame so the duty
//            input only changes on frame boundaries. Holds the last value and
//            flags a sticky underflow when the buffer is empty at a boundary.
// Ports    : clk, rst_n   - clock, async active-low reset
//            s_if (slave) - sample_in / sample_valid / sample_ready stream
//            data_out     - registered sample for the PWM data input
//            frame_tick   - pulse in the first cycle of each frame
//            level        - FIFO occupancy
//            underflow    - sticky empty-at-boundary flag
//            err_clr      - synchronous clear of underflow (set wins)
// Options  : PWM_FEEDER_DITHER_EN - add LFSR bit 0 (0/+1 LSB, saturating) to
//            each popped sample; LFSR advances once per frame.
// Revision : 1.0  initial release
// ============================================================================
module pwm_sample_feeder
   import pwm_sample_feeder_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int FRAME_WIDTH = 10,
   parameter int FIFO_DEPTH  = 8
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   pwm_sample_feeder_if.slave                s_if,
   output logic      [DATA_WIDTH-1:0]        data_out,
   output logic                              frame_tick,
   output logic      [$clog2(FIFO_DEPTH):0]  level,
   output logic                              underflow,
   input  wire logic                         err_clr
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [LVL_W-1:0]       LVL_FULL   = LVL_W'(FIFO_DEPTH);
   localparam logic [FRAME_WIDTH-1:0] FRAME_LAST = '1;

   logic [FRAME_WIDTH-1:0] frame_cnt;
   logic                   frame_end;
   pop_kind_e              pop_kind;
   logic                   push;
   logic                   fifo_pop;
   logic [DATA_WIDTH-1:0]  head;
   logic [DATA_WIDTH-1:0]  next_sample;

   // Ready comes only from registered occupancy, never from sample_valid.
   assign s_if.sample_ready = (level != LVL_FULL);
   assign push              = s_if.sample_valid && s_if.sample_ready;
   assign frame_end         = (frame_cnt == FRAME_LAST);

   // Emptiness is judged on the registered level, so a push landing on the
   // boundary edge cannot rescue that frame; it waits for the next one.
   always_comb begin
      pop_kind = POP_NONE;
      if (frame_end) begin
         pop_kind = (level == '0) ? POP_UNDERFLOW : POP_DATA;
      end
   end

   assign fifo_pop = (pop_kind == POP_DATA);

   sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (s_if.sample_in),
      .pop   (fifo_pop),
      .rdata (head),
      .level (level)
   );

`ifdef PWM_FEEDER_DITHER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= LFSR_SEED;
      end else if (frame_end) begin
         lfsr <= lfsr_next(lfsr);
      end
   end

   // Dither is applied only on a real pop; an underflow hold keeps data_out.
   assign next_sample = DATA_WIDTH'(sat_add(32'(signed'(head)),
                                            {31'd0, lfsr[0]},
                                            DATA_WIDTH));
`else
   assign next_sample = head;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
         data_out   <= '0;
         underflow  <= 1'b0;
      end else begin
         frame_cnt  <= frame_cnt + FRAME_WIDTH'(1);
         // Registered from the last count, so it coincides with new data_out.
         frame_tick <= frame_end;
         if (pop_kind == POP_DATA) data_out <= next_sample;
         if (pop_kind == POP_UNDERFLOW) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/pwm_sample_feeder.md
# pwm_sample_feeder

Rate-matching stage directly upstream of the PWM audio output. It accepts signed demodulated audio samples from the demodulator or decimator chain over a valid/ready handshake and buffers them in a small FIFO. It releases exactly one sample per PWM frame, so the PWM duty-cycle input changes only at frame boundaries. It detects and flags underflow, and holds the last value when the buffer runs dry.

## Interface
- DATA_WIDTH, 12, width of input samples and of `data_out` (two's complement).
- FRAME_WIDTH, 10, frame counter width; frame length is 2^FRAME_WIDTH clocks and must equal the PWM counter width.
- FIFO_DEPTH, 8, buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_WIDTH  signed audio sample.
- sample_valid  in  1  `sample_in` is valid.
- sample_ready  out  1  FIFO can accept a sample.
- data_out  out  DATA_WIDTH  registered sample presented to the PWM `data_in`.
- frame_tick  out  1  one-cycle pulse in the first cycle of each frame.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow  out  1  sticky: a frame boundary found the FIFO empty.
- err_clr  in  1  synchronous clear of `underflow`.

## Operation
- Push occurs when `sample_valid && sample_ready` on a clock edge. `sample_ready = (level != FIFO_DEPTH)`, decoded from registered state only, with no combinational path from `sample_valid`.
- The frame counter (FRAME_WIDTH bits) is free-running and wraps from 2^FRAME_WIDTH−1 to 0.
- Pop occurs on the edge where the counter equals 2^FRAME_WIDTH−1:
  - If the FIFO is non-empty, the head is written into `data_out` and removed.
  - If the FIFO is empty, `data_out` holds its previous value and `underflow` is set.
- Empty is evaluated on the registered `level` before that edge. A push in the same cycle does not rescue the pop; that sample is stored and presented on the next frame.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves `level` unchanged.
- When full, `sample_ready` is 0 and a concurrent pop does not raise it in that same cycle.
- `frame_tick` is high in the cycle where the counter equals 0, which is the same cycle the new `data_out` first appears.
- `err_clr` clears `underflow`. If a new underflow occurs in the same cycle, set wins.
- Pointers are log2(FIFO_DEPTH) bits, wrap naturally, and `level` is tracked separately.

## Timing
- Reset values: `data_out`=0, `frame_tick`=0, `underflow`=0, `level`=0, `sample_ready`=1, frame counter=0.
- The first `frame_tick` occurs 2^FRAME_WIDTH clocks after reset release.
- A sample pushed into an empty FIFO appears on `data_out` at the next frame boundary:
  - worst case 2^FRAME_WIDTH cycles after the push;
  - minimum 1 cycle, when pushed on the cycle where the counter equals 2^FRAME_WIDTH−2.
- `level` reflects a push or pop on the cycle after the edge.
- Assertion of `rst_n` mid-operation immediately empties the FIFO, zeroes `data_out`, and restarts the frame. Buffered samples are discarded.

## Configuration
- `PWM_FEEDER_DITHER_EN` defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances once per frame.
  - LFSR bit 0 adds 0 or +1 LSB to the popped sample before it is registered into `data_out`.
  - The sum saturates at 2^(DATA_WIDTH−1)−1.
  - An underflow hold repeats the previous `data_out` without re-dithering.
- Undefined: the popped sample is passed unmodified, and there is no LFSR logic.

## Structure
- The shared package holds the LFSR polynomial and seed constants and a saturating-add function usable elsewhere in the audio path.
- One sub-module, `sync_fifo`, is natural: parameterised width and depth, with push, pop, head data and level.
- The frame counter, pop control, dither and flags stay in the top level.

## Test plan
Bench parameters are FRAME_WIDTH=4 and FIFO_DEPTH=4, dither off unless stated.
- Reset, then idle 40 cycles → `frame_tick` at cycles 16 and 32, `data_out`=0, `underflow`=1 after the first tick; pulse `err_clr` → `underflow`=0, and it re-sets at the next tick.
- Push 12'h100, 12'h200, 12'h300 back-to-back → `level`=3; `data_out` steps 100→200→300 on successive ticks; 300 is held at the following tick with `underflow`=1.
- Hold `sample_valid`=1 continuously → `sample_ready` falls after 4 accepts and rises the cycle after each pop; no sample is lost or duplicated, checked by scoreboard.
- With the FIFO empty, push on the cycle where the counter equals 15 → that tick reports underflow and holds the old value; the sample appears on the next tick.
- Drop `rst_n` mid-frame with `level`=3 → outputs return to reset values asynchronously; after release, the first tick is 16 cycles later.
- With `PWM_FEEDER_DITHER_EN` defined, push 12'h7FF repeatedly → `data_out` never exceeds 12'h7FF; with input 12'h000, `data_out` ∈ {0,1} following the LFSR bit 0 sequence.
